// File: rtl/memory_access_if.sv
// Data-bus interface between the MEM stage (master) and the data memory (slave).
interface memory_access_if;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/memory_access.sv
// MEM pipeline stage: issues load/store requests on the data bus, stalls while one is
// outstanding, aligns/extends load data and registers the writeback bundle.
// Optional MEM_MISALIGN_CHECK_EN: misaligned memops are trapped instead of issued.
module memory_access (
    input  logic            clk,
    input  logic            resetn,
    input  logic            data_e_valid,
    input  logic [63:0]     data_e_pc,
    input  logic [31:0]     data_e_raw_instr,
    input  logic [63:0]     data_e_alu_out,
    input  logic [63:0]     data_e_mem_write_data,
    input  logic            data_e_memread,
    input  logic            data_e_memwrite,
    input  logic            data_e_mem_unsigned,
    input  logic [1:0]      data_e_mem_size,
    input  logic [4:0]      data_e_dst,
    output logic            stall_m,
    memory_access_if.master dbus,
    output logic            data_m_valid,
    output logic [63:0]     data_m_pc,
    output logic [31:0]     data_m_raw_instr,
    output logic            data_m_memread,
    output logic            data_m_memwrite,
    output logic            data_m_mem_unsigned,
    output logic [1:0]      data_m_mem_size,
    output logic [4:0]      data_m_dst,
    output logic [63:0]     data_m_result
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic            data_m_misalign
`endif
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic        is_mem, misaligned, mis_op, issue;
    logic [2:0]  lane;
    logic [7:0]  strobe_base, strobe_d;
    logic [63:0] wdata_d;
    logic [63:0] load_word, load_ext;

    logic [63:0] req_addr_q;
    logic [1:0]  req_size_q;
    logic [7:0]  req_strobe_q;
    logic [63:0] req_data_q;

    assign is_mem = data_e_valid & (data_e_memread | data_e_memwrite);
    assign lane   = data_e_alu_out[2:0];

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        unique case (data_e_mem_size)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = data_e_alu_out[0];
            2'd2: misaligned = |data_e_alu_out[1:0];
            2'd3: misaligned = |data_e_alu_out[2:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign mis_op = is_mem & misaligned;
    assign issue  = is_mem & ~misaligned;

    // Lane math wraps within the 64-bit word; anything shifted past the top is dropped.
    always_comb begin
        strobe_base = 8'h01;
        unique case (data_e_mem_size)
            2'd0: strobe_base = 8'h01;
            2'd1: strobe_base = 8'h03;
            2'd2: strobe_base = 8'h0F;
            2'd3: strobe_base = 8'hFF;
        endcase
        strobe_d = data_e_memwrite ? (strobe_base << lane) : 8'h00;
        wdata_d  = data_e_memwrite ? (data_e_mem_write_data << {lane, 3'b000}) : 64'd0;
    end

    always_comb begin
        load_word = dbus.dresp_data >> {req_addr_q[2:0], 3'b000};
        load_ext  = load_word;
        unique case (req_size_q)
            2'd0: load_ext = data_e_mem_unsigned ? {56'd0, load_word[7:0]}
                                                 : {{56{load_word[7]}}, load_word[7:0]};
            2'd1: load_ext = data_e_mem_unsigned ? {48'd0, load_word[15:0]}
                                                 : {{48{load_word[15]}}, load_word[15:0]};
            2'd2: load_ext = data_e_mem_unsigned ? {32'd0, load_word[31:0]}
                                                 : {{32{load_word[31]}}, load_word[31:0]};
            2'd3: load_ext = load_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (issue) state_d = StBusy;
            StBusy: if (dbus.dresp_data_ok) state_d = StIdle;
        endcase
    end

    always_comb begin
        dbus.dreq_valid = 1'b0;
        stall_m         = 1'b0;
        unique case (state_q)
            StIdle: stall_m = issue;
            StBusy: begin
                dbus.dreq_valid = 1'b1;
                stall_m         = ~dbus.dresp_data_ok;
            end
        endcase
    end

    assign dbus.dreq_addr   = req_addr_q;
    assign dbus.dreq_size   = {1'b0, req_size_q};
    assign dbus.dreq_strobe = req_strobe_q;
    assign dbus.dreq_data   = req_data_q;

    // Request registers stay frozen for the whole BUSY phase.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_addr_q   <= 64'd0;
            req_size_q   <= 2'd0;
            req_strobe_q <= 8'h00;
            req_data_q   <= 64'd0;
        end else if (state_q == StIdle && issue) begin
            req_addr_q   <= data_e_alu_out;
            req_size_q   <= data_e_mem_size;
            req_strobe_q <= strobe_d;
            req_data_q   <= wdata_d;
        end
    end

    logic misalign_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_m_valid        <= 1'b0;
            data_m_pc           <= 64'd0;
            data_m_raw_instr    <= 32'd0;
            data_m_memread      <= 1'b0;
            data_m_memwrite     <= 1'b0;
            data_m_mem_unsigned <= 1'b0;
            data_m_mem_size     <= 2'd0;
            data_m_dst          <= 5'd0;
            data_m_result       <= 64'd0;
            misalign_q          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        data_m_valid <= 1'b0;
                    end else begin
                        data_m_valid        <= data_e_valid;
                        data_m_pc           <= data_e_pc;
                        data_m_raw_instr    <= data_e_raw_instr;
                        data_m_memread      <= data_e_memread;
                        data_m_memwrite     <= data_e_memwrite;
                        data_m_mem_unsigned <= data_e_mem_unsigned;
                        data_m_mem_size     <= data_e_mem_size;
                        data_m_dst          <= data_e_dst;
                        // A trapped memop reports its address, which is alu_out anyway.
                        data_m_result       <= data_e_alu_out;
                        misalign_q          <= mis_op;
                    end
                end
                StBusy: begin
                    if (dbus.dresp_data_ok) begin
                        data_m_valid        <= 1'b1;
                        data_m_pc           <= data_e_pc;
                        data_m_raw_instr    <= data_e_raw_instr;
                        data_m_memread      <= data_e_memread;
                        data_m_memwrite     <= data_e_memwrite;
                        data_m_mem_unsigned <= data_e_mem_unsigned;
                        data_m_mem_size     <= data_e_mem_size;
                        data_m_dst          <= data_e_dst;
                        data_m_result       <= data_e_memread ? load_ext : 64'd0;
                        misalign_q          <= 1'b0;
                    end else begin
                        data_m_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign data_m_misalign = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule
